// File: rtl/pipeline_hazard_controller_if.sv
// Purpose: bundles the hazard inputs from the pipeline and the stage-control outputs back to it.
// Latency: none. This file carries signals only.
// Backpressure: none. The controller answers with per-stage enables and flushes.
// Ports: master = pipeline side (drives hazard/status inputs), slave = controller side.
interface pipeline_hazard_controller_if;
  logic       enable;
  logic       idex_memread;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_uses_rs2;
  logic       branch_taken_d;
  logic       jalr_taken_e;
  logic       dmem_req;
  logic       dmem_ready;
  logic       halt_req;
  logic       resume;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halted;
  logic       mem_timeout;

  modport master (
    output enable, idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs2,
           branch_taken_d, jalr_taken_e, dmem_req, dmem_ready, halt_req, resume,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, mem_timeout
  );

  modport slave (
    input  enable, idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs2,
           branch_taken_d, jalr_taken_e, dmem_req, dmem_ready, halt_req, resume,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: 5-stage pipeline hazard/stall/flush controller with halt-drain and memory-wait tracking.
// Latency: enables and flushes are combinational from state and inputs. Status and counters are registered.
// Backpressure: a data-memory stall freezes every stage. A load-use hazard holds PC and IF/ID.
// Ports: clk, reset (sync, active-high), hz (slave side of the hazard interface),
//        stall_count / flush_count (saturating CNT_W-bit performance counters).
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  pipeline_hazard_controller_if.slave hz,
  output logic [CNT_W-1:0]          stall_count,
  output logic [CNT_W-1:0]          flush_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int TMR_W   = (MEM_TIMEOUT  < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  state_t               ret_q, ret_d;      // state to return to when the memory wait ends
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [TMR_W-1:0]     wait_q, wait_d;
  logic                 timeout_q, timeout_d;

  logic mem_stall, load_use;
  logic live;
  logic act_mem, act_rel, act_jalr, act_lu, act_br;
  logic stall_inc, flush_inc;

  assign mem_stall = hz.dmem_req & ~hz.dmem_ready;
  assign load_use  = hz.idex_memread & (hz.idex_rd != 5'd0) &
                     ((hz.idex_rd == hz.ifid_rs1) |
                      (hz.ifid_uses_rs2 & (hz.idex_rd == hz.ifid_rs2)));

  // Exactly one action is selected per enabled cycle, in priority order.
  assign act_mem  = hz.enable & mem_stall & (state_q != S_HALTED);
  assign act_rel  = hz.enable & ~mem_stall & (state_q == S_MEM_WAIT);
  assign live     = hz.enable & ~mem_stall & ((state_q == S_RUN) | (state_q == S_DRAIN));
  assign act_jalr = live & hz.jalr_taken_e;
  assign act_lu   = live & ~hz.jalr_taken_e & load_use;
  assign act_br   = live & ~hz.jalr_taken_e & ~load_use & hz.branch_taken_d;

  assign stall_inc = act_mem | act_lu;
  // The IF/ID bubbles forced while draining are not redirects, so a branch
  // only counts in RUN. A JALR flush is a real redirect in either state.
  assign flush_inc = act_jalr | (act_br & (state_q == S_RUN));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      ret_q       <= S_RUN;
      drain_q     <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      drain_q   <= drain_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (stall_inc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    drain_d   = drain_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (act_mem) begin
      if (wait_q != TMR_W'(MEM_TIMEOUT))
        wait_d = wait_q + 1'b1;
      if (wait_q >= TMR_W'(MEM_TIMEOUT - 1))
        timeout_d = 1'b1;
      if (state_q != S_MEM_WAIT) begin
        state_d = S_MEM_WAIT;
        ret_d   = state_q;
        // A halt arriving together with a stall still takes effect: the
        // wait returns straight into DRAIN.
        if ((state_q == S_RUN) && hz.halt_req) begin
          ret_d   = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
    end else if (hz.enable) begin
      unique case (state_q)
        S_RUN: begin
          if (hz.halt_req) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end
        S_MEM_WAIT: begin
          state_d = ret_q;
          wait_d  = '0;
        end
        S_DRAIN: begin
          // A load-use hold does not advance the pipeline, so it does not count down.
          if (!act_lu) begin
            if (drain_q <= DRAIN_W'(1)) begin
              drain_d = '0;
              state_d = S_HALTED;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
        end
        S_HALTED: begin
          if (hz.resume)
            state_d = S_RUN;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    hz.pc_en       = 1'b0;
    hz.ifid_en     = 1'b0;
    hz.idex_en     = 1'b0;
    hz.exmem_en    = 1'b0;
    hz.memwb_en    = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.halted      = (state_q == S_HALTED);
    hz.mem_timeout = timeout_q;
    if (reset) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (!hz.enable || act_mem || (state_q == S_HALTED)) begin
      // All stages frozen.
    end else if (act_rel) begin
      hz.pc_en    = 1'b1;
      hz.ifid_en  = 1'b1;
      hz.idex_en  = 1'b1;
      hz.exmem_en = 1'b1;
      hz.memwb_en = 1'b1;
    end else begin
      hz.pc_en    = 1'b1;
      hz.ifid_en  = 1'b1;
      hz.idex_en  = 1'b1;
      hz.exmem_en = 1'b1;
      hz.memwb_en = 1'b1;
      if (act_jalr) begin
        hz.ifid_flush = 1'b1;
        hz.idex_flush = 1'b1;
      end else if (act_lu) begin
        hz.pc_en      = 1'b0;
        hz.ifid_en    = 1'b0;
        hz.idex_flush = 1'b1;
      end else if (act_br) begin
        hz.ifid_flush = 1'b1;
      end
      // Draining stops fetch and feeds bubbles into IF/ID. A held load-use
      // instruction stays in IF/ID until it can issue.
      if (state_q == S_DRAIN) begin
        hz.pc_en = 1'b0;
        if (!act_lu)
          hz.ifid_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Purpose: scoreboard bench for pipeline_hazard_controller driven by directed vectors.
// Latency: each vector is checked in the same cycle it is applied.
// Backpressure: none. The monitor drains the expectation queue on every falling edge.
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [1:0] fl;   // {ifid_flush, idex_flush}
    logic       h;
    logic       to;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  logic clk;
  logic reset;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller #(
    .DRAIN_CYCLES(4),
    .MEM_TIMEOUT (16),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hz         (hz),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    n_push = 0;
  int    n_pop = 0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    stim_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    hz.enable        = 1'b1;
    hz.idex_memread  = 1'b0;
    hz.idex_rd       = 5'd0;
    hz.ifid_rs1      = 5'd0;
    hz.ifid_rs2      = 5'd0;
    hz.ifid_uses_rs2 = 1'b0;
    hz.branch_taken_d = 1'b0;
    hz.jalr_taken_e  = 1'b0;
    hz.dmem_req      = 1'b0;
    hz.dmem_ready    = 1'b0;
    hz.halt_req      = 1'b0;
    hz.resume        = 1'b0;
  endtask

  task automatic set_lu(input int rd, input int rs1);
    hz.idex_memread = 1'b1;
    hz.idex_rd      = 5'(rd);
    hz.ifid_rs1     = 5'(rs1);
  endtask

  // Queue the expected response for the inputs currently applied, then advance one cycle.
  task automatic chk(input logic [4:0] en, input logic [1:0] fl, input logic h,
                     input logic to, input int sc, input int fc, input string nm);
    exp_t e;
    e.en = en; e.fl = fl; e.h = h; e.to = to; e.sc = 8'(sc); e.fc = 8'(fc);
    exp_q.push_back(e);
    name_q.push_back(nm);
    n_push++;
    @(posedge clk); #1;
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    cyc++;
    while (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_pop++;
      a.en = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en};
      a.fl = {hz.ifid_flush, hz.idex_flush};
      a.h  = hz.halted;
      a.to = hz.mem_timeout;
      a.sc = stall_count;
      a.fc = flush_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @cyc %0d: got en=%b fl=%b halted=%b to=%b sc=%0d fc=%0d, want en=%b fl=%b halted=%b to=%b sc=%0d fc=%0d",
                 nm, cyc, a.en, a.fl, a.h, a.to, a.sc, a.fc,
                 e.en, e.fl, e.h, e.to, e.sc, e.fc);
      end
    end
    if (stim_done) begin
      checks++;
      if (n_pop != n_push) begin
        errors++;
        $display("FAIL scoreboard_count: got %0d popped, want %0d pushed", n_pop, n_push);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (cyc > 5000) begin
      checks++;
      errors++;
      $display("FAIL watchdog: got %0d cycles without completion, want at most 5000", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(5'b00000, 2'b11, 0, 0, 0, 0, "reset");
    reset = 1'b0;
    chk(5'b11111, 2'b00, 0, 0, 0, 0, "idle");

    // Load-use detection
    set_lu(5, 5);
    chk(5'b00111, 2'b01, 0, 0, 0, 0, "load_use_rs1");
    set_lu(0, 0);
    chk(5'b11111, 2'b00, 0, 0, 1, 0, "rd_zero_no_stall");
    set_lu(7, 3); hz.ifid_rs2 = 5'd7; hz.ifid_uses_rs2 = 1'b1;
    chk(5'b00111, 2'b01, 0, 0, 1, 0, "load_use_rs2");
    hz.ifid_uses_rs2 = 1'b0;
    chk(5'b11111, 2'b00, 0, 0, 2, 0, "rs2_unused");

    // Redirect priorities
    clr(); hz.branch_taken_d = 1'b1;
    chk(5'b11111, 2'b10, 0, 0, 2, 0, "branch");
    set_lu(5, 5);
    chk(5'b00111, 2'b01, 0, 0, 2, 1, "load_use_beats_branch");
    hz.jalr_taken_e = 1'b1;
    chk(5'b11111, 2'b11, 0, 0, 3, 1, "jalr_beats_load_use");
    clr();
    chk(5'b11111, 2'b00, 0, 0, 3, 2, "idle_after_jalr");

    // Global enable freeze
    set_lu(5, 5); hz.jalr_taken_e = 1'b1; hz.dmem_req = 1'b1; hz.enable = 1'b0;
    chk(5'b00000, 2'b00, 0, 0, 3, 2, "disabled");
    clr();
    chk(5'b11111, 2'b00, 0, 0, 3, 2, "counts_frozen");

    // Three-cycle memory stall then release
    hz.dmem_req = 1'b1;
    chk(5'b00000, 2'b00, 0, 0, 3, 2, "mem_stall_1");
    chk(5'b00000, 2'b00, 0, 0, 4, 2, "mem_stall_2");
    chk(5'b00000, 2'b00, 0, 0, 5, 2, "mem_stall_3");
    hz.dmem_ready = 1'b1;
    chk(5'b11111, 2'b00, 0, 0, 6, 2, "mem_release");
    clr(); hz.jalr_taken_e = 1'b1;
    chk(5'b11111, 2'b11, 0, 0, 6, 2, "run_after_mem");
    clr();
    chk(5'b11111, 2'b00, 0, 0, 6, 3, "idle_after_mem");

    // Halt, drain, resume
    hz.halt_req = 1'b1;
    chk(5'b11111, 2'b00, 0, 0, 6, 3, "halt_req");
    hz.halt_req = 1'b0;
    for (int i = 0; i < 4; i++)
      chk(5'b01111, 2'b10, 0, 0, 6, 3, "drain");
    chk(5'b00000, 2'b00, 1, 0, 6, 3, "halted");
    hz.branch_taken_d = 1'b1; hz.halt_req = 1'b1;
    chk(5'b00000, 2'b00, 1, 0, 6, 3, "halted_ignores_inputs");
    clr(); hz.resume = 1'b1;
    chk(5'b00000, 2'b00, 1, 0, 6, 3, "resume_pulse");
    chk(5'b11111, 2'b00, 0, 0, 6, 3, "run_after_resume");
    clr();
    chk(5'b11111, 2'b00, 0, 0, 6, 3, "resume_ignored_in_run");

    // Reset in the middle of a drain
    hz.halt_req = 1'b1;
    chk(5'b11111, 2'b00, 0, 0, 6, 3, "halt_req_2");
    hz.halt_req = 1'b0;
    chk(5'b01111, 2'b10, 0, 0, 6, 3, "drain_2");
    reset = 1'b1;
    chk(5'b00000, 2'b11, 0, 0, 6, 3, "reset_in_drain");
    reset = 1'b0;
    for (int i = 0; i < 5; i++)
      chk(5'b11111, 2'b00, 0, 0, 0, 0, "no_pending_halt");

    // Memory timeout: the flag is sticky, stalling continues, and reset clears it
    hz.dmem_req = 1'b1;
    for (int k = 0; k <= 16; k++)
      chk(5'b00000, 2'b00, 0, (k == 16), k, 0, "mem_wait_long");
    hz.dmem_ready = 1'b1;
    chk(5'b11111, 2'b00, 0, 1, 17, 0, "timeout_release");
    clr();
    chk(5'b11111, 2'b00, 0, 1, 17, 0, "timeout_sticky");
    reset = 1'b1;
    chk(5'b00000, 2'b11, 0, 1, 17, 0, "reset_with_timeout");
    reset = 1'b0;
    chk(5'b11111, 2'b00, 0, 0, 0, 0, "timeout_cleared");

    // Reset in the middle of a memory wait
    hz.dmem_req = 1'b1;
    chk(5'b00000, 2'b00, 0, 0, 0, 0, "mw_a");
    chk(5'b00000, 2'b00, 0, 0, 1, 0, "mw_b");
    reset = 1'b1;
    chk(5'b00000, 2'b11, 0, 0, 2, 0, "reset_in_mem_wait");
    reset = 1'b0; hz.dmem_req = 1'b0;
    chk(5'b11111, 2'b00, 0, 0, 0, 0, "run_after_mw_reset");

    // Counter saturation with 2^CNT_W+2 load-use cycles
    set_lu(5, 5);
    for (int k = 0; k < (1 << CNT_W) + 2; k++)
      chk(5'b00111, 2'b01, 0, 0, (k > 255) ? 255 : k, 0, "stall_saturate");
    clr();
    chk(5'b11111, 2'b00, 0, 0, 255, 0, "stall_saturated_hold");

    stim_done = 1'b1;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4: bubble cycles issued after halt_req before HALTED.
REQ-002 Parameter MEM_TIMEOUT, default 16: consecutive MEM_WAIT cycles before mem_timeout sets.
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  global run enable; 0 freezes the controller and pipeline.
REQ-007 idex_memread  input  1  EX-stage instruction is a load.
REQ-008 idex_rd  input  5  EX-stage destination register.
REQ-009 ifid_rs1, ifid_rs2  input  5 each  ID-stage source registers.
REQ-010 ifid_uses_rs2  input  1  ID-stage instruction reads rs2.
REQ-011 branch_taken_d  input  1  ID-stage redirect (taken BEQ or JAL).
REQ-012 jalr_taken_e  input  1  EX-stage redirect (JALR).
REQ-013 dmem_req  input  1  MEM-stage instruction accesses data memory.
REQ-014 dmem_ready  input  1  data memory completes the access this cycle.
REQ-015 halt_req, resume  input  1 each  halt and restart requests, one-cycle pulses.
REQ-016 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  per-stage register enables.
REQ-017 ifid_flush, idex_flush  output  1 each  load a bubble into that stage register.
REQ-018 halted  output  1  controller is in HALTED.
REQ-019 mem_timeout  output  1  sticky memory-timeout error.
REQ-020 stall_count, flush_count  output  CNT_W each  saturating performance counters.

Function
REQ-021 The FSM SHALL have states RUN, MEM_WAIT, DRAIN and HALTED; the enables and flushes SHALL be combinational from state and inputs.
REQ-022 mem_stall = dmem_req & !dmem_ready.
REQ-023 load_use = idex_memread & (idex_rd != 0) & (idex_rd == ifid_rs1 | (ifid_uses_rs2 & idex_rd == ifid_rs2)).
REQ-024 Priority SHALL be: reset, then !enable, then mem_stall, then jalr_taken_e, then load_use, then branch_taken_d, then none.
REQ-025 reset=1: all enables 0; ifid_flush=1; idex_flush=1.
REQ-026 enable=0: all enables 0 and all flushes 0; state, counters and timers hold.
REQ-027 mem_stall in RUN or DRAIN: all enables 0; flushes 0; next state MEM_WAIT; wait timer increments.
REQ-028 MEM_WAIT with dmem_ready=1: all enables 1 for that cycle; wait timer clears; next state is the state MEM_WAIT was entered from.
REQ-029 The wait timer reaching MEM_TIMEOUT SHALL set mem_timeout, which stays set until reset; stalling continues.
REQ-030 jalr_taken_e: all enables 1; ifid_flush=1; idex_flush=1.
REQ-031 load_use: pc_en=0; ifid_en=0; idex_flush=1; other enables 1.
REQ-032 branch_taken_d: all enables 1; ifid_flush=1.
REQ-033 When load_use and branch_taken_d occur together, load_use SHALL win and the branch SHALL be re-evaluated next cycle.
REQ-034 halt_req in RUN SHALL cause a transition to DRAIN and load drain counter = DRAIN_CYCLES.
- A halt_req seen in any other state SHALL be ignored.
REQ-035 In DRAIN: pc_en=0; ifid_flush=1; other enables 1.
- The drain counter decrements on each non-stalled cycle.
- The state goes to HALTED in the cycle after the counter reaches 0.
REQ-036 In HALTED: all enables 0; halted=1; resume causes a transition to RUN next cycle.
- A resume seen in any other state SHALL be ignored.
REQ-037 stall_count SHALL increment on each enabled cycle with mem_stall or load_use active.
REQ-038 flush_count SHALL increment on each enabled cycle with a jalr_taken_e or branch_taken_d flush.
- DRAIN bubbles SHALL NOT be counted.
REQ-039 Both counters SHALL saturate at all-ones.

Reset
REQ-040 Reset SHALL set: state=RUN; drain counter=0; wait timer=0; mem_timeout=0; halted=0; stall_count=0; flush_count=0.
REQ-041 Reset asserted mid-DRAIN or mid-MEM_WAIT SHALL return the controller to RUN in the next cycle, with no pending halt or wait carried over.

Verification
REQ-042 idex_memread=1, idex_rd=5, ifid_rs1=5 -> for one cycle: pc_en=0, ifid_en=0, idex_flush=1; stall_count 0->1.
- Repeat with idex_rd=0 -> no stall.
REQ-043 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, then 1; stall_count=3; return to RUN.
REQ-044 jalr_taken_e=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_en=1; flush_count +1; stall_count unchanged.
REQ-045 halt_req pulse with DRAIN_CYCLES=4 -> pc_en=0 and ifid_flush=1 for 4 cycles, then halted=1 with all enables 0.
- A resume pulse then gives RUN the next cycle.
REQ-046 dmem_ready held at 0 for 16 cycles -> mem_timeout=1 and stays 1 after dmem_ready=1; reset clears mem_timeout.
REQ-047 Preload via 2^CNT_W+2 load_use cycles -> stall_count stays at all-ones.
